// File: rtl/prog_rom_arbiter.sv
// Program ROM read-port arbiter: CPU fetch has priority, debug readback uses free slots.
// Optional fairness (forced DBG slot after FAIR_LIMIT denials) enabled by PROG_ARB_FAIR_EN.
//
// state     | meaning
// S_IDLE    | no debug read outstanding; a DBG grant may be issued
// S_DBG_CAP | ROM output holds the debug word; capture into dbg_data_q
module prog_rom_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 18,
  parameter int FAIR_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_en_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_stall_o,
  output logic [DATA_W-1:0] cpu_ir_o,
  output logic              cpu_ir_valid_o,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic              dbg_valid_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_ir_i
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_e;
  typedef enum logic {S_IDLE, S_DBG_CAP} state_e;

  if (FAIR_LIMIT < 1) begin : g_bad_limit
    $error("prog_rom_arbiter: FAIR_LIMIT must be at least 1");
  end

  owner_e            owner_q;
  state_e            state_q;
  logic [DATA_W-1:0] held_ir_q;
  logic [DATA_W-1:0] dbg_data_q;
  logic              dbg_valid_q;
  logic              force_dbg;
  logic              dbg_grant;

  // Gated by reset so no ACK leaks out while the block is held in reset.
  assign dbg_grant = rst_n_i && dbg_req_i && (state_q == S_IDLE) && (!cpu_en_i || force_dbg);

`ifdef PROG_ARB_FAIR_EN
  localparam int CNT_W = $clog2(FAIR_LIMIT + 2);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_dbg   = (starve_q == CNT_W'(FAIR_LIMIT));
  assign cpu_stall_o = dbg_grant && cpu_en_i;

  always_comb begin
    starve_d = starve_q;
    if (!dbg_req_i || dbg_grant)
      starve_d = '0;
    else if (state_q == S_IDLE)
      starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`else
  assign force_dbg   = 1'b0;
  assign cpu_stall_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q     <= OWN_NONE;
      state_q     <= S_IDLE;
      held_ir_q   <= '0;
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      owner_q     <= dbg_grant ? OWN_DBG : OWN_CPU;
      dbg_valid_q <= 1'b0;
      if (owner_q == OWN_CPU)
        held_ir_q <= rom_ir_i;
      case (state_q)
        S_IDLE: begin
          if (dbg_grant)
            state_q <= S_DBG_CAP;
        end
        S_DBG_CAP: begin
          dbg_data_q  <= rom_ir_i;
          dbg_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr_o     = dbg_grant ? dbg_addr_i : cpu_addr_i;
  assign dbg_ack_o      = dbg_grant;
  assign cpu_ir_valid_o = (owner_q == OWN_CPU);
  assign cpu_ir_o       = (owner_q == OWN_CPU) ? rom_ir_i : held_ir_q;
  assign dbg_data_o     = dbg_data_q;
  assign dbg_valid_o    = dbg_valid_q;

endmodule
